// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch timer initiator:
// timer register map, control words, FSM states and helpers.
package stopwatch_pkg;

    localparam logic [2:0] REG_STATUS    = 3'd0;
    localparam logic [2:0] REG_CONTROL   = 3'd1;
    localparam logic [2:0] REG_PERIOD_LO = 3'd2;
    localparam logic [2:0] REG_PERIOD_HI = 3'd3;
    localparam logic [2:0] REG_SNAP_LO   = 3'd4;
    localparam logic [2:0] REG_SNAP_HI   = 3'd5;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    localparam logic [15:0] CTL_INIT =
        16'((1 << CTL_ITO) | (1 << CTL_CONT));
    localparam logic [15:0] CTL_RUN  =
        CTL_INIT | 16'(1 << CTL_START);
    localparam logic [15:0] CTL_HALT =
        CTL_INIT | 16'(1 << CTL_STOP);

    typedef enum logic [3:0] {
        INIT_PL, INIT_PH, INIT_CTL, IDLE,
        CLR_STS, WR_START, WR_STOP, CLR_PL,
        SNAP_WR, SNAP_RL, SNAP_RH, SNAP_DONE
    } state_t;

    function automatic logic [31:0] load_value(
        input int unsigned cycles
    );
        return 32'(cycles - 32'd1);
    endfunction

    // Two-digit BCD +1 with no wrap; callers handle the modulus.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0}
                                : {v[7:4], v[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/stopwatch_tick_master_bcd_time_counter.sv
// Cascaded BCD mm:ss:cc counter advanced one centisecond per inc.
// Minutes wrap to 00 after MAX_MINUTES-1.
module bcd_time_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX_MINUTES = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] m,
    output logic [7:0] s,
    output logic [7:0] cs
);

    localparam int         ML     = MAX_MINUTES - 1;
    localparam logic [7:0] M_LAST = {4'(ML / 10), 4'(ML % 10)};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m  <= '0;
            s  <= '0;
            cs <= '0;
        end else if (clr) begin
            m  <= '0;
            s  <= '0;
            cs <= '0;
        end else if (inc) begin
            if (cs != 8'h99) begin
                cs <= bcd_inc(cs);
            end else begin
                cs <= '0;
                if (s != 8'h59) begin
                    s <= bcd_inc(s);
                end else begin
                    s <= '0;
                    m <= (m == M_LAST) ? 8'h00 : bcd_inc(m);
                end
            end
        end
    end

endmodule

// File: rtl/stopwatch_tick_master.sv
// Avalon-MM initiator that runs the interval timer as a
// stopwatch: programs it, services its IRQ and captures laps.
module stopwatch_tick_master
    import stopwatch_pkg::*;
#(
    parameter int PERIOD_CYCLES = 500000,
    parameter int MAX_MINUTES   = 60
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_start_stop,
    input  logic        cmd_clear,
    input  logic        cmd_lap,
    output logic [2:0]  av_address,
    output logic        av_chipselect,
    output logic        av_write_n,
    output logic [15:0] av_writedata,
    input  logic [15:0] av_readdata,
    input  logic        timer_irq,
    output logic        running,
    output logic [7:0]  time_m,
    output logic [7:0]  time_s,
    output logic [7:0]  time_cs,
    output logic        lap_valid,
    output logic [23:0] lap_time,
    output logic [31:0] lap_frac,
    output logic        busy
);

    localparam logic [31:0] LOAD = load_value(PERIOD_CYCLES);

    state_t state, state_nxt;
    logic   up;
    logic   pend_ss, pend_clr, pend_lap, clr_seq;
    logic   take_ss, take_clr, take_lap;
    logic   bus_wr, bus_rd;

    // Bus stays idle for the first cycle after reset release.
    always_comb begin
        state_nxt    = state;
        bus_wr       = 1'b0;
        bus_rd       = 1'b0;
        av_address   = '0;
        av_writedata = '0;
        take_ss      = 1'b0;
        take_clr     = 1'b0;
        take_lap     = 1'b0;
        if (up) begin
            case (state)
                INIT_PL: begin
                    bus_wr       = 1'b1;
                    av_address   = REG_PERIOD_LO;
                    av_writedata = LOAD[15:0];
                    state_nxt    = INIT_PH;
                end
                INIT_PH: begin
                    bus_wr       = 1'b1;
                    av_address   = REG_PERIOD_HI;
                    av_writedata = LOAD[31:16];
                    state_nxt    = INIT_CTL;
                end
                INIT_CTL: begin
                    bus_wr       = 1'b1;
                    av_address   = REG_CONTROL;
                    av_writedata = CTL_INIT;
                    state_nxt    = IDLE;
                end
                IDLE: begin
                    if (timer_irq) begin
                        state_nxt = CLR_STS;
                    end else if (pend_clr || cmd_clear) begin
                        take_clr  = 1'b1;
                        state_nxt = WR_STOP;
                    end else if (pend_ss || cmd_start_stop) begin
                        take_ss   = 1'b1;
                        state_nxt = running ? WR_STOP : WR_START;
                    end else if (pend_lap || cmd_lap) begin
                        take_lap  = 1'b1;
                        state_nxt = SNAP_WR;
                    end
                end
                CLR_STS: begin
                    bus_wr     = 1'b1;
                    av_address = REG_STATUS;
                    state_nxt  = IDLE;
                end
                WR_START: begin
                    bus_wr       = 1'b1;
                    av_address   = REG_CONTROL;
                    av_writedata = CTL_RUN;
                    state_nxt    = IDLE;
                end
                WR_STOP: begin
                    bus_wr       = 1'b1;
                    av_address   = REG_CONTROL;
                    av_writedata = CTL_HALT;
                    state_nxt    = clr_seq ? CLR_PL : IDLE;
                end
                CLR_PL: begin
                    bus_wr       = 1'b1;
                    av_address   = REG_PERIOD_LO;
                    av_writedata = LOAD[15:0];
                    state_nxt    = IDLE;
                end
                SNAP_WR: begin
                    bus_wr     = 1'b1;
                    av_address = REG_SNAP_LO;
                    state_nxt  = SNAP_RL;
                end
                SNAP_RL: begin
                    bus_rd     = 1'b1;
                    av_address = REG_SNAP_LO;
                    state_nxt  = SNAP_RH;
                end
                SNAP_RH: begin
                    bus_rd     = 1'b1;
                    av_address = REG_SNAP_HI;
                    state_nxt  = SNAP_DONE;
                end
                SNAP_DONE: state_nxt = IDLE;
                default:   state_nxt = INIT_PL;
            endcase
        end
        av_chipselect = bus_wr | bus_rd;
        av_write_n    = ~bus_wr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT_PL;
            up        <= 1'b0;
            pend_ss   <= 1'b0;
            pend_clr  <= 1'b0;
            pend_lap  <= 1'b0;
            clr_seq   <= 1'b0;
            running   <= 1'b0;
            lap_valid <= 1'b0;
            lap_time  <= '0;
            lap_frac  <= '0;
        end else begin
            up        <= 1'b1;
            state     <= state_nxt;
            // A clear also discards queued start/stop and lap.
            pend_ss   <= (pend_ss | cmd_start_stop)
                         & ~(take_ss | take_clr);
            pend_clr  <= (pend_clr | cmd_clear) & ~take_clr;
            pend_lap  <= (pend_lap | cmd_lap)
                         & ~(take_lap | take_clr);
            lap_valid <= (state == SNAP_DONE);
            if (take_clr)
                clr_seq <= 1'b1;
            else if (state == CLR_PL)
                clr_seq <= 1'b0;
            case (state)
                WR_START:  running <= 1'b1;
                WR_STOP:   running <= 1'b0;
                CLR_PL:    running <= 1'b0;
                SNAP_WR:   lap_time <= {time_m, time_s, time_cs};
                SNAP_RH:   lap_frac[15:0] <= av_readdata;
                SNAP_DONE: lap_frac[31:16] <= av_readdata;
                default: ;
            endcase
        end
    end

    assign busy = up && (state != IDLE);

    bcd_time_counter #(
        .MAX_MINUTES(MAX_MINUTES)
    ) u_time (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    ((state == CLR_STS) && running),
        .clr    (state == CLR_PL),
        .m      (time_m),
        .s      (time_s),
        .cs     (time_cs)
    );

endmodule

// File: tb/tb_stopwatch_tick_master.sv
// Bench for stopwatch_tick_master: timer slave model, bus
// monitor and scoreboards for bus cycles and lap captures.
module tb_stopwatch_tick_master;

    localparam int          MAXM    = 2;
    localparam logic [15:0] SNAP_LO = 16'h1234;
    localparam logic [15:0] SNAP_HI = 16'h0007;
    localparam logic [19:0] ST_WR   = {1'b1, 3'd0, 16'h0000};

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_start_stop = 1'b0;
    logic        cmd_clear = 1'b0;
    logic        cmd_lap = 1'b0;
    logic [2:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata = 16'h0;
    logic        timer_irq = 1'b0;
    logic        running;
    logic [7:0]  time_m, time_s, time_cs;
    logic        lap_valid;
    logic [23:0] lap_time;
    logic [31:0] lap_frac;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int irq_req = 0;
    int irq_seen = 0;
    int cyc = 0;
    int snap_cyc = 0;
    int model = 0;

    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];
    logic [55:0] lap_exp_q[$];
    logic [55:0] lap_obs_q[$];
    int          lapv_q[$];

    stopwatch_tick_master #(
        .PERIOD_CYCLES(500000),
        .MAX_MINUTES  (MAXM)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_start_stop(cmd_start_stop),
        .cmd_clear     (cmd_clear),
        .cmd_lap       (cmd_lap),
        .av_address    (av_address),
        .av_chipselect (av_chipselect),
        .av_write_n    (av_write_n),
        .av_writedata  (av_writedata),
        .av_readdata   (av_readdata),
        .timer_irq     (timer_irq),
        .running       (running),
        .time_m        (time_m),
        .time_s        (time_s),
        .time_cs       (time_cs),
        .lap_valid     (lap_valid),
        .lap_time      (lap_time),
        .lap_frac      (lap_frac),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Timer slave: read latency 1, IRQ held until status write.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (av_chipselect && av_write_n)
            av_readdata <= (av_address == 3'd4) ? SNAP_LO :
                           (av_address == 3'd5) ? SNAP_HI : 16'h0;
        else
            av_readdata <= 16'h0;
        if (av_chipselect && !av_write_n && av_address == 3'd0)
            timer_irq <= 1'b0;
        else if (irq_req != irq_seen) begin
            timer_irq <= 1'b1;
            irq_seen  <= irq_req;
        end
    end

    always @(negedge clk) begin
        if (av_chipselect) begin
            obs_q.push_back({~av_write_n, av_address, av_writedata});
            if (!av_write_n && av_address == 3'd4)
                snap_cyc = cyc;
        end
        if (lap_valid) begin
            lap_obs_q.push_back({lap_time, lap_frac});
            lapv_q.push_back(cyc);
        end
    end

    function automatic logic [23:0] bcd_of(input int t);
        int m, s, c;
        m = t / 6000;
        s = (t / 100) % 60;
        c = t % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10),
                4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic pulse(input logic ss, input logic cl,
                         input logic lp);
        cmd_start_stop = ss;
        cmd_clear      = cl;
        cmd_lap        = lp;
        @(negedge clk);
        cmd_start_stop = 1'b0;
        cmd_clear      = 1'b0;
        cmd_lap        = 1'b0;
    endtask

    task automatic settle(input int need);
        int k = 0;
        while (obs_q.size() < need && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic tick(output bit ok);
        int k = 0;
        irq_req++;
        @(negedge clk);
        while (timer_irq === 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        ok = (timer_irq === 1'b0);
    endtask

    task automatic do_ticks(input int n, input bit inc,
                            output int bad);
        bit ok;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            tick(ok);
            if (!ok) bad++;
            if (inc) model = (model + 1) % (MAXM * 6000);
        end
        repeat (3) @(negedge clk);
        if (obs_q.size() != n) bad++;
        while (obs_q.size() > 0)
            if (obs_q.pop_front() !== ST_WR) bad++;
    endtask

    task automatic test_reset();
        logic [19:0] e, o;
        repeat (3) @(negedge clk);
        checks++;
        if ({av_chipselect, av_address, av_writedata, running,
             time_m, time_s, time_cs, lap_valid, lap_time,
             lap_frac, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got nonzero want 0");
        end
        checks++;
        if (av_write_n !== 1'b1) begin
            errors++;
            $display("FAIL reset_write_n got %b want 1", av_write_n);
        end
        exp_q.push_back({1'b1, 3'd2, 16'hA11F});
        exp_q.push_back({1'b1, 3'd3, 16'h0007});
        exp_q.push_back({1'b1, 3'd1, 16'h0003});
        reset_n = 1'b1;
        settle(exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hFFFFF;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL init_bus got %h want %h", o, e);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL init_extra got %0d want 0", obs_q.size());
            obs_q.delete();
        end
        checks++;
        if ({busy, av_chipselect, av_write_n} !== 3'b001) begin
            errors++;
            $display("FAIL init_idle got %b want 001",
                     {busy, av_chipselect, av_write_n});
        end
    endtask

    task automatic test_start_ticks();
        logic [19:0] e, o;
        bit ok;
        exp_q.push_back({1'b1, 3'd1, 16'h0007});
        pulse(1'b1, 1'b0, 1'b0);
        settle(exp_q.size());
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ST_WR);
            tick(ok);
            model++;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL irq_drop got 1 want 0");
            end
        end
        settle(exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hFFFFF;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL run_bus got %h want %h", o, e);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL run_extra got %0d want 0", obs_q.size());
            obs_q.delete();
        end
        checks++;
        if ({running, time_m, time_s, time_cs} !== {1'b1, bcd_of(3)})
        begin
            errors++;
            $display("FAIL run_time got %b %h%h%h want 1 %h", running,
                     time_m, time_s, time_cs, bcd_of(3));
        end
    endtask

    task automatic test_lap();
        logic [19:0] e, o;
        logic [55:0] le, lo;
        int bad;
        do_ticks(1231, 1'b1, bad);
        checks++;
        if (bad != 0 || {time_m, time_s, time_cs} !== bcd_of(model))
        begin
            errors++;
            $display("FAIL lap_pre got %h%h%h bad %0d want %h 0",
                     time_m, time_s, time_cs, bad, bcd_of(model));
        end
        exp_q.push_back({1'b1, 3'd4, 16'h0000});
        exp_q.push_back({1'b0, 3'd4, 16'h0000});
        exp_q.push_back({1'b0, 3'd5, 16'h0000});
        lap_exp_q.push_back({bcd_of(model), SNAP_HI, SNAP_LO});
        pulse(1'b0, 1'b0, 1'b1);
        settle(exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hFFFFF;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL lap_bus got %h want %h", o, e);
            end
        end
        checks++;
        if (lap_obs_q.size() != 1) begin
            errors++;
            $display("FAIL lap_pulses got %0d want 1",
                     lap_obs_q.size());
        end
        while (lap_exp_q.size() > 0) begin
            le = lap_exp_q.pop_front();
            lo = (lap_obs_q.size() > 0) ? lap_obs_q.pop_front() : '1;
            checks++;
            if (lo !== le) begin
                errors++;
                $display("FAIL lap_data got %h want %h", lo, le);
            end
        end
        checks++;
        if (lapv_q.size() == 0 || lapv_q[0] - snap_cyc != 4) begin
            errors++;
            $display("FAIL lap_latency got %0d want 4",
                     (lapv_q.size() > 0) ? lapv_q[0] - snap_cyc : -1);
        end
        lap_obs_q.delete();
        lapv_q.delete();
    endtask

    task automatic test_wrap();
        int bad;
        int steps[4];
        steps = '{5999 - model, 1, 5999, 1};
        foreach (steps[i]) begin
            do_ticks(steps[i], 1'b1, bad);
            checks++;
            if (bad != 0 || {time_m, time_s, time_cs} !== bcd_of(model))
            begin
                errors++;
                $display("FAIL wrap_%0d got %h%h%h bad %0d want %h",
                         i, time_m, time_s, time_cs, bad,
                         bcd_of(model));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] e, o;
        exp_q.push_back(ST_WR);
        exp_q.push_back({1'b1, 3'd1, 16'h000B});
        irq_req++;
        @(negedge clk);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        model++;
        settle(exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hFFFFF;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_bus got %h want %h", o, e);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_extra got %0d want 0", obs_q.size());
            obs_q.delete();
        end
        checks++;
        if ({running, time_m, time_s, time_cs}
            !== {1'b0, bcd_of(model)}) begin
            errors++;
            $display("FAIL b2b_state got %b %h%h%h want 0 %h", running,
                     time_m, time_s, time_cs, bcd_of(model));
        end
    endtask

    task automatic test_stopped_irq();
        int bad;
        do_ticks(1, 1'b0, bad);
        checks++;
        if (bad != 0 || {time_m, time_s, time_cs} !== bcd_of(model))
        begin
            errors++;
            $display("FAIL stop_irq got %h%h%h bad %0d want %h",
                     time_m, time_s, time_cs, bad, bcd_of(model));
        end
    endtask

    task automatic test_clear_in_lap();
        logic [19:0] e, o;
        logic [55:0] lo;
        exp_q.push_back({1'b1, 3'd4, 16'h0000});
        exp_q.push_back({1'b0, 3'd4, 16'h0000});
        exp_q.push_back({1'b0, 3'd5, 16'h0000});
        exp_q.push_back({1'b1, 3'd1, 16'h000B});
        exp_q.push_back({1'b1, 3'd2, 16'hA11F});
        lap_exp_q.push_back({bcd_of(model), SNAP_HI, SNAP_LO});
        pulse(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        pulse(1'b1, 1'b1, 1'b0);
        model = 0;
        settle(exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hFFFFF;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL clr_bus got %h want %h", o, e);
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL clr_extra got %0d want 0", obs_q.size());
            obs_q.delete();
        end
        while (lap_exp_q.size() > 0) begin
            lo = (lap_obs_q.size() > 0) ? lap_obs_q.pop_front() : '1;
            checks++;
            if (lo !== lap_exp_q[0]) begin
                errors++;
                $display("FAIL clr_lap got %h want %h", lo,
                         lap_exp_q[0]);
            end
            void'(lap_exp_q.pop_front());
        end
        checks++;
        if ({running, time_m, time_s, time_cs, busy} !== '0) begin
            errors++;
            $display("FAIL clr_state got %b %h%h%h %b want all 0",
                     running, time_m, time_s, time_cs, busy);
        end
        lap_obs_q.delete();
        lapv_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [19:0] e, o;
        pulse(1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({av_chipselect, running, lap_valid, lap_frac, busy,
             ~av_write_n} !== '0) begin
            errors++;
            $display("FAIL mid_reset got cs %b run %b frac %h busy %b",
                     av_chipselect, running, lap_frac, busy);
        end
        obs_q.delete();
        lap_obs_q.delete();
        lapv_q.delete();
        exp_q.push_back({1'b1, 3'd2, 16'hA11F});
        exp_q.push_back({1'b1, 3'd3, 16'h0007});
        exp_q.push_back({1'b1, 3'd1, 16'h0003});
        reset_n = 1'b1;
        settle(exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hFFFFF;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mid_init got %h want %h", o, e);
            end
        end
        checks++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_idle got extra %0d busy %b want 0 0",
                     obs_q.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_start_ticks();
        test_lap();
        test_wrap();
        test_back_to_back();
        test_stopped_irq();
        test_clear_in_lap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
